// File: rtl/booth_seq_ctrl.sv
// Sequential signed multiplier: one radix-4 Booth digit of M per clock,
// DATA_WIDTH/2 RUN cycles, with a one-cycle done pulse and held results.
module booth_seq_ctrl #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] Q,
    input  logic [DATA_WIDTH-1:0] M,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result_hi,
    output logic [DATA_WIDTH-1:0] result_lo
);

    localparam int unsigned PW     = 2 * DATA_WIDTH;
    localparam int unsigned DIGITS = DATA_WIDTH / 2;
    localparam int unsigned CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] mcand_q;
    logic [DATA_WIDTH-1:0] mplier_q;
    logic [PW-1:0]         acc_q;
    logic [CNT_W-1:0]      cnt_q;

    logic [DATA_WIDTH:0]   m_ext;
    logic [2:0]            digit;
    logic [PW-1:0]         q_ext;
    logic [PW-1:0]         pp;
    logic [PW-1:0]         acc_next;

    // Appending a zero below the LSB supplies Mcap[-1] for digit 0.
    assign m_ext = {mplier_q, 1'b0};

    always_comb begin
        digit = 3'(m_ext >> {cnt_q, 1'b0});
        q_ext = {{DATA_WIDTH{mcand_q[DATA_WIDTH-1]}}, mcand_q};
        pp    = '0;
        case (digit)
            3'b001, 3'b010: pp = q_ext;
            3'b011:         pp = q_ext << 1;
            3'b100:         pp = -(q_ext << 1);
            3'b101, 3'b110: pp = -q_ext;
            default:        pp = '0;
        endcase
        acc_next = acc_q + (pp << {cnt_q, 1'b0});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result_hi <= '0;
            result_lo <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        mcand_q  <= Q;
                        mplier_q <= M;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy     <= 1'b1;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    acc_q <= acc_next;
                    if (cnt_q == LAST_DIGIT) begin
                        result_hi <= acc_next[PW-1:DATA_WIDTH];
                        result_lo <= acc_next[DATA_WIDTH-1:0];
                        done      <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl: directed corner cases plus random
// operands checked against a plain signed-multiply reference.
module tb_booth_seq_ctrl;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] Q;
    logic [W-1:0] M;
    logic         busy;
    logic         done;
    logic [W-1:0] result_hi;
    logic [W-1:0] result_lo;

    int checks;
    int errors;

    booth_seq_ctrl #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .Q         (Q),
        .M         (M),
        .busy      (busy),
        .done      (done),
        .result_hi (result_hi),
        .result_lo (result_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [W-1:0] q, input logic [W-1:0] m);
        longint p;
        p = longint'($signed(q)) * longint'($signed(m));
        return 64'(p);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One start pulse, then watch 24 cycles; optionally re-pulse start with
    // other operands mid-run, which must have no effect.
    task automatic do_op(input logic [W-1:0] q, input logic [W-1:0] m, input string tag,
                         input bit disturb);
        logic [63:0] exp;
        int done_at;
        int done_cnt;
        int busy_cnt;
        exp = model(q, m);
        Q = q;
        M = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        done_at = -1;
        done_cnt = 0;
        busy_cnt = 0;
        for (int c = 0; c < 24; c++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
                check({tag, "_res_at_done"}, {result_hi, result_lo}, exp);
            end
            if (disturb && c == 5) begin
                Q = $urandom;
                M = $urandom;
                start = 1'b1;
            end
            if (disturb && c == 7) start = 1'b0;
            tick();
        end
        check({tag, "_done_cycle"}, 64'(done_at), 64'(16));
        check({tag, "_done_count"}, 64'(done_cnt), 64'(1));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(17));
        check({tag, "_res_held"}, {result_hi, result_lo}, exp);
    endtask

    initial begin
        logic [W-1:0] ql [3];
        logic [W-1:0] ml [3];
        int k;
        int pulses;
        bit bad;
        checks = 0;
        errors = 0;

        // Reset with start held high: nothing may be captured.
        rst = 1'b1;
        start = 1'b1;
        Q = 32'd5;
        M = 32'd7;
        #2;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_res", {result_hi, result_lo}, 64'(0));
        tick();
        tick();
        check("reset_start_ignored", 64'(busy), 64'(0));
        start = 1'b0;
        rst = 1'b0;
        tick();
        check("idle_after_release", 64'(busy), 64'(0));

        do_op(32'd3, 32'd4, "q3_m4", 1'b0);
        check("q3_m4_const", {result_hi, result_lo}, 64'h0000_0000_0000_000C);
        do_op(32'hFFFF_FFF9, 32'd5, "qm7_m5", 1'b0);
        check("qm7_m5_const", {result_hi, result_lo}, 64'hFFFF_FFFF_FFFF_FFDD);
        do_op(32'h8000_0000, 32'h8000_0000, "minmin", 1'b0);
        check("minmin_const", {result_hi, result_lo}, 64'h4000_0000_0000_0000);
        do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, "max_m1", 1'b0);
        check("max_m1_const", {result_hi, result_lo}, 64'hFFFF_FFFF_8000_0001);

        do_op(32'h1234_5678, 32'hFEDC_BA98, "restart_ignored", 1'b1);

        for (int i = 0; i < 8; i++) begin
            do_op($urandom, $urandom, $sformatf("rand%0d", i), 1'b0);
        end

        // Reset mid-run: abandon with no done pulse, results cleared.
        Q = 32'd1000;
        M = 32'd77;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        rst = 1'b1;
        #2;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_res", {result_hi, result_lo}, 64'(0));
        tick();
        rst = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done || busy || result_hi != 0 || result_lo != 0) bad = 1'b1;
            tick();
        end
        check("midrst_quiet", 64'(bad), 64'(0));
        do_op(32'd2, 32'd3, "after_rst", 1'b0);
        check("after_rst_lo", 64'(result_lo), 64'h6);

        // Back-to-back with start held high: captures every 18 cycles.
        for (int i = 0; i < 3; i++) begin
            ql[i] = $urandom;
            ml[i] = $urandom;
        end
        Q = ql[0];
        M = ml[0];
        start = 1'b1;
        tick();
        k = 0;
        pulses = 0;
        for (int c = 0; c < 62; c++) begin
            if (c % 18 == 0 && c / 18 < 2) begin
                Q = ql[c/18+1];
                M = ml[c/18+1];
            end
            if (c == 37) start = 1'b0;
            if (done) begin
                pulses++;
                if (k < 3) begin
                    check($sformatf("b2b%0d_cycle", k), 64'(c), 64'(16 + 18 * k));
                    check($sformatf("b2b%0d_res", k), {result_hi, result_lo}, model(ql[k], ml[k]));
                end
                k++;
            end
            tick();
        end
        check("b2b_pulses", 64'(pulses), 64'(3));
        check("b2b_idle_end", 64'(busy), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_seq_ctrl.md
BOOTH_SEQ_CTRL -- requirements
Module: booth_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the operand width; the value SHALL be even and at least 4.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin a multiply; sampled on rising clk.
REQ-005 SHALL have port Q, input, DATA_WIDTH bits: multiplicand, signed two's complement.
REQ-006 SHALL have port M, input, DATA_WIDTH bits: multiplier, signed two's complement; Booth-recoded.
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-009 SHALL have port result_hi, output, DATA_WIDTH bits: upper half of the signed product (HI).
REQ-010 SHALL have port result_lo, output, DATA_WIDTH bits: lower half of the signed product (LO).

Function
REQ-011 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-012 SHALL, in IDLE with start=1 at a rising edge, capture Q and M into internal registers, clear the 2*DATA_WIDTH accumulator, set the digit counter to 0 and enter RUN.
REQ-013 SHALL ignore start when the FSM is in RUN or DONE: no re-capture, no restart and no effect on the operation in progress.
REQ-014 SHALL, at each RUN edge, process one radix-4 Booth digit, formed from bits {Mcap[2i+1], Mcap[2i], Mcap[2i-1]} with Mcap[-1]=0, where i is the counter value.
REQ-015 SHALL map the Booth digit to a partial product as follows: 000 and 111 give 0; 001 and 010 give +Q; 011 gives +2Q; 100 gives -2Q; 101 and 110 give -Q.
REQ-016 SHALL sign-extend Q to 2*DATA_WIDTH bits, shift the partial product left by 2i, and add it to the accumulator modulo 2^(2*DATA_WIDTH).
REQ-017 SHALL, when the counter equals DATA_WIDTH/2-1, process the final digit, write the final accumulator value to {result_hi, result_lo} on the same edge and enter DONE.
REQ-018 SHALL otherwise increment the counter by 1 on each RUN edge.
REQ-019 SHALL make the latency exactly DATA_WIDTH/2 RUN cycles: with the start edge numbered 0, done is high between edge DATA_WIDTH/2 and edge DATA_WIDTH/2+1 (16 and 17 for the default width).
REQ-020 SHALL move from DONE to IDLE unconditionally on the next edge; done SHALL be high only in DONE.
REQ-021 SHALL drive busy high in RUN and DONE and low in IDLE; busy and done SHALL be registered or decoded from state only, with no combinational path from start.
REQ-022 SHALL hold result_hi and result_lo from the DONE update until the next DONE update, including throughout a following RUN.
REQ-023 SHALL produce the exact signed product for all operand pairs, including the most-negative value times the most-negative value.
REQ-024 SHALL accept a start asserted in the cycle right after DONE (state IDLE) with no idle gap required.

Reset
REQ-025 SHALL, while rst=1, asynchronously force state to IDLE, counter to 0, accumulator to 0, busy=0, done=0, result_hi=0 and result_lo=0.
REQ-026 SHALL, on reset asserted mid-RUN, abandon the operation with no done pulse, and SHALL leave the results at 0 after release.
REQ-027 SHALL ignore start on any edge where rst=1; the first capture SHALL occur on the first rising edge with rst=0 and start=1.

Verification
REQ-028 SHALL test Q=3, M=4 with start pulsed in IDLE -> busy=1 for 17 cycles; done high only in cycle 16 after the start edge; result_hi=0x00000000, result_lo=0x0000000C.
REQ-029 SHALL test Q=-7 (0xFFFFFFF9), M=5 -> {result_hi, result_lo} = 0xFFFFFFFF_FFFFFFDD.
REQ-030 SHALL test Q=M=0x80000000 -> result_hi=0x40000000, result_lo=0x00000000; then Q=0x7FFFFFFF, M=0xFFFFFFFF -> result_hi=0xFFFFFFFF, result_lo=0x80000001.
REQ-031 SHALL test start re-pulsed during RUN with different operands -> the first product completes unchanged at the original cycle, and the new operands are not captured.
REQ-032 SHALL test rst asserted at RUN cycle 8, then released -> immediate IDLE with all outputs 0 and no done pulse; a fresh start of 2*3 then returns result_lo=0x00000006.
REQ-033 SHALL test back-to-back operation with start held high continuously -> a new operation begins every 18 cycles, each with exactly one done pulse and a correct result.
